// File: rtl/cover_pixel_fetch.sv
// Cover-image pixel fetch: 2x-scaled SRAM image with a frame-paced fade in/out.
// Three-stage pipeline from VGA coordinates to rgb_out; the fade FSM sets the brightness.
module cover_pixel_fetch #(
    parameter int unsigned IMG_W       = 320,
    parameter int unsigned IMG_H       = 200,
    parameter int unsigned Y_OFFSET    = 40,
    parameter int unsigned FADE_FRAMES = 4,
    parameter logic [7:0]  KEY_COLOR   = 8'hE3,
    parameter logic [11:0] BG_RGB      = 12'h000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        video_on,
    input  logic        pixel_tick,
    input  logic        start,
    input  logic        hide,
    output logic        sram_en,
    output logic        sram_we,
    output logic [15:0] sram_addr,
    input  logic [7:0]  sram_data,
    output logic [11:0] rgb_out,
    output logic        video_on_d,
    output logic [1:0]  fade_state
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StFadeIn  = 2'd1,
        StShow    = 2'd2,
        StFadeOut = 2'd3
    } state_e;

    localparam logic [10:0] WinXEnd = 11'(2 * IMG_W);
    localparam logic [10:0] WinYBeg = 11'(Y_OFFSET);
    localparam logic [10:0] WinYEnd = 11'(Y_OFFSET + 2 * IMG_H);
    localparam logic [3:0]  LvlMax  = 4'd8;
    localparam logic [7:0]  CntLast = 8'(FADE_FRAMES - 1);

    state_e      state_q;
    logic [3:0]  level_q;
    logic [7:0]  frame_cnt_q;

    logic        in_win;
    logic        frame_start;
    logic        last_frame;
    logic [9:0]  y_rel;
    logic [9:0]  row;
    logic [9:0]  col;
    logic [15:0] addr_d, addr_q;
    logic        en_q, win1_q, vid1_q;
    logic        win2_q, vid2_q, en2_q;
    logic [11:0] rgb_d, rgb_q;
    logic        vid3_q;
    logic [3:0]  r4, g4, b4;

    assign in_win = ({1'b0, pixel_x} < WinXEnd) &&
                    ({1'b0, pixel_y} >= WinYBeg) &&
                    ({1'b0, pixel_y} < WinYEnd);

    assign y_rel = pixel_y - 10'(Y_OFFSET);
    assign row   = y_rel >> 1;
    assign col   = pixel_x >> 1;

    // row * IMG_W as a sum of shifted rows, one term per set bit of IMG_W.
    always_comb begin
        addr_d = {6'b0, col};
        for (int i = 0; i < 16; i++) begin
            if (IMG_W[i]) begin
                addr_d = addr_d + ({6'b0, row} << i);
            end
        end
    end

    function automatic logic [3:0] scale(input logic [3:0] chan, input logic [3:0] lvl);
        logic [7:0] prod;
        prod = {4'b0, chan} * {4'b0, lvl};
        return 4'(prod >> 3);
    endfunction

    assign r4 = {sram_data[7:5], sram_data[7]};
    assign g4 = {sram_data[4:2], sram_data[4]};
    assign b4 = {sram_data[1:0], sram_data[1:0]};

    // en2_q low means the SRAM was not read for this pixel, so its data is stale.
    always_comb begin
        rgb_d = 12'h000;
        if (!vid2_q) begin
            rgb_d = 12'h000;
        end else if (!win2_q || !en2_q || (sram_data == KEY_COLOR) || (state_q == StIdle)) begin
            rgb_d = BG_RGB;
        end else begin
            rgb_d = {scale(r4, level_q), scale(g4, level_q), scale(b4, level_q)};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= 16'h0000;
            en_q   <= 1'b0;
            win1_q <= 1'b0;
            vid1_q <= 1'b0;
            win2_q <= 1'b0;
            vid2_q <= 1'b0;
            en2_q  <= 1'b0;
            rgb_q  <= 12'h000;
            vid3_q <= 1'b0;
        end else begin
            if (in_win) begin
                addr_q <= addr_d;
            end
            en_q   <= in_win & video_on & (state_q != StIdle);
            win1_q <= in_win;
            vid1_q <= video_on;
            win2_q <= win1_q;
            vid2_q <= vid1_q;
            en2_q  <= en_q;
            rgb_q  <= rgb_d;
            vid3_q <= vid2_q;
        end
    end

    assign frame_start = pixel_tick && (pixel_x == 10'd0) && (pixel_y == 10'd0);
    assign last_frame  = (frame_cnt_q == CntLast);

    // hide takes priority over start in every state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            level_q     <= 4'd0;
            frame_cnt_q <= 8'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && !hide) begin
                        state_q     <= StFadeIn;
                        frame_cnt_q <= 8'd0;
                    end
                end
                StFadeIn: begin
                    if (hide) begin
                        state_q     <= StFadeOut;
                        frame_cnt_q <= 8'd0;
                    end else if (frame_start) begin
                        if (last_frame) begin
                            frame_cnt_q <= 8'd0;
                            if (level_q < LvlMax) begin
                                level_q <= level_q + 4'd1;
                            end
                            if (level_q >= LvlMax - 4'd1) begin
                                state_q <= StShow;
                            end
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                        end
                    end
                end
                StShow: begin
                    if (hide) begin
                        state_q     <= StFadeOut;
                        frame_cnt_q <= 8'd0;
                    end
                end
                StFadeOut: begin
                    if (start && !hide) begin
                        state_q     <= StFadeIn;
                        frame_cnt_q <= 8'd0;
                    end else if (frame_start) begin
                        if (last_frame) begin
                            frame_cnt_q <= 8'd0;
                            if (level_q > 4'd0) begin
                                level_q <= level_q - 4'd1;
                            end
                            if (level_q <= 4'd1) begin
                                state_q <= StIdle;
                            end
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign sram_en    = en_q;
    assign sram_we    = 1'b0;
    assign sram_addr  = addr_q;
    assign rgb_out    = rgb_q;
    assign video_on_d = vid3_q;
    assign fade_state = state_q;

endmodule

// File: tb/tb_cover_pixel_fetch.sv
// Randomized scoreboard bench for cover_pixel_fetch against an arithmetic reference model.
module tb_cover_pixel_fetch;

    localparam int KEY = 8'hE3;
    localparam int BG  = 12'h000;
    localparam int FF  = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  pixel_x, pixel_y;
    logic        video_on, pixel_tick, start, hide;
    logic        sram_en, sram_we;
    logic [15:0] sram_addr;
    logic [7:0]  sram_data;
    logic [11:0] rgb_out;
    logic        video_on_d;
    logic [1:0]  fade_state;

    always #5 clk = ~clk;

    cover_pixel_fetch dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .video_on  (video_on),
        .pixel_tick(pixel_tick),
        .start     (start),
        .hide      (hide),
        .sram_en   (sram_en),
        .sram_we   (sram_we),
        .sram_addr (sram_addr),
        .sram_data (sram_data),
        .rgb_out   (rgb_out),
        .video_on_d(video_on_d),
        .fade_state(fade_state)
    );

    typedef struct {
        int en;
        int addr;
        int st;
        bit has_rgb;
        int rgb;
        int vd;
    } exp_t;

    typedef struct {
        int vid;
        int win;
        int addr;
    } hist_t;

    exp_t  exp_q[$];
    hist_t hist[$];

    int tests = 0;
    int fails = 0;
    int m_st, m_lvl, m_cnt, m_addr_hold;
    int force_x = -1;
    int force_y = -1;
    logic [15:0] addr_prev;

    int bx[8] = '{0, 639, 640, 10, 639, 0, 1, 320};
    int by[8] = '{40, 439, 100, 39, 40, 439, 41, 0};

    // Cover SRAM contents: address 0 white, some transparent, some pure red.
    function automatic int mem(int a);
        if (a == 0) return 8'hFF;
        if (a % 23 == 5) return KEY;
        if (a % 7 == 3) return 8'hE0;
        return ((a * 37) ^ (a >> 3)) & 8'hFF;
    endfunction

    function automatic int expect_rgb(int vid, int win, int data, int st, int lvl);
        int r, g, b, rr, gg, bb;
        if (vid == 0) return 0;
        if (win == 0 || data == KEY || st == 0) return BG;
        r  = (data >> 5) & 7;
        g  = (data >> 2) & 7;
        b  = data & 3;
        rr = (r * 2 + r / 4) * lvl / 8;
        gg = (g * 2 + g / 4) * lvl / 8;
        bb = (b * 5) * lvl / 8;
        return rr * 256 + gg * 16 + bb;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_st        = 0;
        m_lvl       = 0;
        m_cnt       = 0;
        m_addr_hold = 0;
        addr_prev   = 16'h0000;
        hist.delete();
        exp_q.delete();
    endtask

    task automatic step(input bit st_i, input bit hd_i, input bit fs_i);
        int x, y, sel, win, fs;
        exp_t  e;
        hist_t h;
        @(negedge clk);
        sram_data = 8'(mem(int'(addr_prev)));
        addr_prev = sram_addr;
        if (fs_i) begin
            x = 0; y = 0; pixel_tick = 1'b1;
        end else if (force_x >= 0) begin
            x = force_x; y = force_y; pixel_tick = 1'b0;
        end else begin
            if ($urandom_range(0, 3) == 0) begin
                sel = $urandom_range(0, 7);
                x = bx[sel]; y = by[sel];
            end else begin
                x = $urandom_range(0, 799);
                y = $urandom_range(0, 524);
            end
            pixel_tick = 1'($urandom_range(0, 1));
        end
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = (force_x >= 0) ? 1'b1 : ($urandom_range(0, 9) != 0);
        start    = st_i;
        hide     = hd_i;

        win = (x < 640 && y >= 40 && y < 440) ? 1 : 0;
        if (win != 0) m_addr_hold = ((y - 40) / 2) * 320 + x / 2;
        e.en   = (win != 0 && video_on && m_st != 0) ? 1 : 0;
        e.addr = m_addr_hold;
        hist.push_back('{int'(video_on), win, m_addr_hold});
        e.has_rgb = 1'b0;
        e.rgb     = 0;
        e.vd      = 0;
        if (hist.size() == 3) begin
            h = hist.pop_front();
            e.has_rgb = 1'b1;
            e.rgb     = expect_rgb(h.vid, h.win, mem(h.addr), m_st, m_lvl);
            e.vd      = h.vid;
        end

        fs = (pixel_tick && x == 0 && y == 0) ? 1 : 0;
        if (hd_i && (m_st == 1 || m_st == 2)) begin
            m_st = 3; m_cnt = 0;
        end else if (st_i && !hd_i && (m_st == 0 || m_st == 3)) begin
            m_st = 1; m_cnt = 0;
        end else if (fs != 0 && (m_st == 1 || m_st == 3)) begin
            if (m_cnt == FF - 1) begin
                m_cnt = 0;
                m_lvl = (m_st == 1) ? m_lvl + 1 : m_lvl - 1;
                if (m_lvl >= 8) begin m_lvl = 8; m_st = 2; end
                if (m_lvl <= 0) begin m_lvl = 0; m_st = 0; end
            end else begin
                m_cnt++;
            end
        end
        e.st = m_st;
        exp_q.push_back(e);
    endtask

    task automatic run(input int n, input int period);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, period > 0 && (i % period) == period - 1);
    endtask

    task automatic run_until(input int tst, input int tlvl, input int budget);
        int i = 0;
        while (!(m_st == tst && (tlvl < 0 || m_lvl == tlvl)) && i < budget) begin
            step(1'b0, 1'b0, (i % 6) == 5);
            i++;
        end
        tests++;
        if (i >= budget) begin
            fails++;
            $display("FAIL run_until: budget %0d expired, state %0d level %0d", budget, m_st, m_lvl);
        end
    endtask

    task automatic forced(input int x, input int y, input int n);
        force_x = x;
        force_y = y;
        run(n, 0);
        force_x = -1;
        force_y = -1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_sram_en", sram_en, 0);
        chk("rst_sram_we", sram_we, 0);
        chk("rst_sram_addr", sram_addr, 0);
        chk("rst_rgb_out", rgb_out, 0);
        chk("rst_video_on_d", video_on_d, 0);
        chk("rst_fade_state", fade_state, 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sram_en", sram_en, e.en);
                chk("sram_addr", sram_addr, e.addr);
                chk("fade_state", fade_state, e.st);
                if (e.has_rgb) begin
                    chk("rgb_out", rgb_out, e.rgb);
                    chk("video_on_d", video_on_d, e.vd);
                end
            end
        end
    end

    initial begin
        reset_n    = 1'b0;
        pixel_x    = '0;
        pixel_y    = '0;
        video_on   = 1'b0;
        pixel_tick = 1'b0;
        start      = 1'b0;
        hide       = 1'b0;
        sram_data  = '0;
        model_reset();
        #12;
        check_reset_outputs();
        @(negedge clk);
        reset_n = 1'b1;

        run(40, 0);
        step(1'b1, 1'b0, 1'b0);
        run_until(2, -1, 2000);
        forced(0, 40, 4);
        forced(639, 439, 3);
        forced(640, 100, 3);
        forced(10, 39, 3);
        forced(10, 40, 3);
        step(1'b1, 1'b0, 1'b0);
        run(60, 0);

        step(1'b0, 1'b1, 1'b0);
        run_until(3, 4, 2000);
        forced(6, 40, 4);
        run_until(0, -1, 2000);

        step(1'b1, 1'b0, 1'b0);
        run_until(1, 3, 2000);
        step(1'b1, 1'b1, 1'b0);
        forced(6, 40, 3);
        run(20, 6);
        step(1'b1, 1'b0, 1'b0);
        run_until(2, -1, 2000);
        step(1'b0, 1'b1, 1'b0);
        run(30, 6);

        @(posedge clk);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        reset_n = 1'b1;

        run(40, 0);
        step(1'b1, 1'b0, 1'b0);
        run(50, 6);
        @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
